// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1 UART transmitter. Bytes written through wr_en/wr_data are
//   queued in a small FIFO. Each byte is sent on txd LSB first, framed by a
//   start bit, an optional parity bit and one stop bit. Frames go out
//   back-to-back for as long as the FIFO holds data.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (2..65535)
//   FIFO_DEPTH    FIFO entries, power of two, >= 2
//   PARITY_EN     1 inserts a parity bit after the data bits
//   PARITY_ODD    0 even parity, 1 odd parity (only used when PARITY_EN=1)
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   wr_en    in   write strobe, one byte per cycle
//   wr_data  in   byte to queue
//   full     out  FIFO occupancy equals FIFO_DEPTH
//   count    out  FIFO occupancy
//   ovf      out  one-cycle pulse after a write was dropped because full
//   busy     out  high whenever the transmit FSM is not idle
//   txd      out  serial output, idles high, driven from a flop
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        ovf,
    output logic                        busy,
    output logic                        txd
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;

    // Transmit FSM state
    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          txd_q;
    logic          busy_q;

    logic          full_w;
    logic          wr_ok;
    logic          baud_end;
    logic          pop;
    logic [7:0]    head_w;
    logic          head_par;

    // full comes from the registered count, so a write and a pop on the same
    // edge while full still drops the write.
    assign full_w   = (count_q == CW'(FIFO_DEPTH));
    assign wr_ok    = wr_en && !full_w;
    assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign head_w   = mem_q[rd_ptr_q];
    assign head_par = (^head_w) ^ (PARITY_ODD != 0);

    // A byte leaves the FIFO when idle, or on the last cycle of a stop bit so
    // the next start bit follows with no idle gap.
    assign pop = (count_q != '0) &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));

    always_comb begin
        count_d = count_q;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array carries no reset; only the pointers and count define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            ovf_q   <= wr_en && full_w;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (pop) begin
                        state_q <= S_START;
                        shift_q <= head_w;
                        par_q   <= head_par;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end

                S_START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        state_q <= S_DATA;
                        txd_q   <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end

                S_DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q <= S_PARITY;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            // Present the next data bit at the boundary so
                            // txd stays a pure flop output.
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end

                S_PARITY: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        state_q <= S_STOP;
                        txd_q   <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end

                S_STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            state_q <= S_START;
                            shift_q <= head_w;
                            par_q   <= head_par;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    baud_q  <= '0;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign full  = full_w;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign busy  = busy_q;
    assign txd   = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Four instances of uart_tx_fifo:
//     dut 0 : CLKS_PER_BIT=4, no parity   (directed frame, FIFO, reset tests)
//     dut 1 : CLKS_PER_BIT=4, even parity
//     dut 2 : CLKS_PER_BIT=4, odd parity
//     dut 3 : CLKS_PER_BIT=2, no parity   (random traffic)
//   Stimulus pushes the expected line pattern of each frame into a per-DUT
//   queue; one receiver process per DUT detects start bits, checks every
//   cycle of the frame against the popped pattern and logs start times.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_o;

    logic       wr_en_a, wr_en_b, wr_en_c, wr_en_d;
    logic [7:0] wr_data_a, wr_data_b, wr_data_c, wr_data_d;
    logic       full_a, full_b, full_c, full_d;
    logic [2:0] count_a, count_b, count_c, count_d;
    logic       ovf_a, ovf_b, ovf_c, ovf_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       txd_a, txd_b, txd_c, txd_d;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_data(wr_data_a), .full(full_a),
        .count(count_a), .ovf(ovf_a), .busy(busy_a), .txd(txd_a));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst_o), .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b),
        .count(count_b), .ovf(ovf_b), .busy(busy_b), .txd(txd_b));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .rst(rst_o), .wr_en(wr_en_c), .wr_data(wr_data_c), .full(full_c),
        .count(count_c), .ovf(ovf_c), .busy(busy_c), .txd(txd_c));
    uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_d (
        .clk(clk), .rst(rst_o), .wr_en(wr_en_d), .wr_data(wr_data_d), .full(full_d),
        .count(count_d), .ovf(ovf_d), .busy(busy_d), .txd(txd_d));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ovf_cnt_d = 0;

    // Expected frame patterns, bit 0 = start bit, transmitted LSB first.
    logic [10:0] exp_q [4][$];
    int          start_cyc [4][$];
    int          rx_cnt [4];

    int cnt_seq [5] = '{1, 1, 2, 3, 4};

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ovf_d === 1'b1) ovf_cnt_d <= ovf_cnt_d + 1;

    function automatic logic get_txd(input int idx);
        case (idx)
            0:       return txd_a;
            1:       return txd_b;
            2:       return txd_c;
            default: return txd_d;
        endcase
    endfunction

    function automatic logic get_rst(input int idx);
        return (idx == 0) ? rst_a : rst_o;
    endfunction

    // 8N1 pattern: start 0, data LSB first, stop 1.
    function automatic logic [10:0] frame8n1(input logic [7:0] d);
        return {1'b1, 1'b1, d, 1'b0};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Samples one frame, one sample per cycle, starting at the current
    // negedge (first start-bit cycle). Aborts if the DUT is put in reset.
    task automatic rx_frame(input int idx, input int cpb, input int nbits,
                            input logic [10:0] expbits, output logic [7:0] got,
                            output int errs, output bit aborted);
        logic t;
        int   b;
        errs    = 0;
        got     = '0;
        aborted = 1'b0;
        for (int c = 0; c < nbits * cpb; c++) begin
            if (get_rst(idx) === 1'b0) begin
                aborted = 1'b1;
                return;
            end
            t = get_txd(idx);
            b = c / cpb;
            if (t !== expbits[b]) errs++;
            if (b >= 1 && b <= 8 && (c % cpb) == cpb / 2) got[b-1] = t;
            @(negedge clk);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_mon
        initial begin
            logic [10:0] e;
            logic [7:0]  got;
            int          errs;
            int          nb;
            int          cp;
            bit          ab;
            cp = (gi == 3) ? 2 : 4;
            nb = (gi == 1 || gi == 2) ? 11 : 10;
            rx_cnt[gi] = 0;
            forever begin
                if (get_txd(gi) === 1'b0 && get_rst(gi) === 1'b1) begin
                    start_cyc[gi].push_back(cyc);
                    if (exp_q[gi].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame dut%0d at cycle %0d required=none", gi, cyc);
                        e = 11'h7FF;
                    end else begin
                        e = exp_q[gi].pop_front();
                    end
                    rx_frame(gi, cp, nb, e, got, errs, ab);
                    if (ab) begin
                        $display("note dut%0d frame aborted by reset", gi);
                    end else begin
                        total++;
                        if (errs != 0) begin
                            bad++;
                            $display("FAIL frame dut%0d actual=%02h bad_cycles=%0d required=%02h",
                                     gi, got, errs, e[8:1]);
                        end else begin
                            $display("ok   frame dut%0d byte=%02h", gi, got);
                        end
                        rx_cnt[gi]++;
                    end
                end else begin
                    @(negedge clk);
                end
            end
        end
    end

    task automatic wait_idle_a(input int budget);
        int k = 0;
        while (busy_a !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            total++;
            bad++;
            $display("FAIL idle_wait actual=busy required=idle");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rx(input int idx, input int n, input int budget);
        int k = 0;
        while (rx_cnt[idx] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("rx_count_dut%0d", idx), rx_cnt[idx], n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rx_before;
        int n;

        rst_a = 1'b0;
        rst_o = 1'b0;
        wr_en_a = 0; wr_en_b = 0; wr_en_c = 0; wr_en_d = 0;
        wr_data_a = 0; wr_data_b = 0; wr_data_c = 0; wr_data_d = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_txd", txd_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_full", full_a, 0);
        chk("rst_ovf", ovf_a, 0);
        rst_a = 1'b1;
        rst_o = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames: 0x55 no parity, 0x07 even and odd parity
        wr_en_a = 1; wr_data_a = 8'h55;
        wr_en_b = 1; wr_data_b = 8'h07;
        wr_en_c = 1; wr_data_c = 8'h07;
        exp_q[0].push_back(11'h2AA);
        exp_q[1].push_back(11'h60E);
        exp_q[2].push_back(11'h40E);
        @(negedge clk);
        wr_en_a = 0; wr_en_b = 0; wr_en_c = 0;
        chk("wr_count", count_a, 1);
        chk("wr_txd_idle", txd_a, 1);
        chk("wr_busy_idle", busy_a, 0);
        @(negedge clk);
        chk("pop_count", count_a, 0);
        chk("pop_txd_start", txd_a, 0);
        chk("pop_busy", busy_a, 1);
        chk("pop_txd_start_par", txd_b, 0);
        repeat (39) @(negedge clk);
        chk("stop_busy_c40", busy_a, 1);
        chk("stop_txd_c40", txd_a, 1);
        @(negedge clk);
        chk("end_busy_c41", busy_a, 0);
        chk("end_txd_c41", txd_a, 1);
        chk("par_busy_c41", busy_b, 1);
        repeat (3) @(negedge clk);
        chk("par_busy_c44", busy_b, 1);
        @(negedge clk);
        chk("par_even_busy_c45", busy_b, 0);
        chk("par_odd_busy_c45", busy_c, 0);
        wait_rx(0, 1, 100);
        wait_rx(1, 1, 100);
        wait_rx(2, 1, 100);

        // FIFO fill with overflow, back-to-back frames
        wait_idle_a(200);
        base      = start_cyc[0].size();
        rx_before = rx_cnt[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) chk($sformatf("fill_count_%0d", i), count_a, cnt_seq[i-1]);
            if (i == 5) begin
                chk("fill_full", full_a, 1);
                chk("fill_ovf_before", ovf_a, 0);
            end
            wr_en_a = 1;
            wr_data_a = 8'(i);
            if (i < 5) exp_q[0].push_back(frame8n1(8'(i)));
        end
        @(negedge clk);
        wr_en_a = 0;
        chk("drop_count", count_a, 4);
        chk("drop_ovf", ovf_a, 1);
        @(negedge clk);
        chk("drop_ovf_once", ovf_a, 0);
        wait_rx(0, rx_before + 5, 400);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("b2b_gap_%0d", k), start_cyc[0][base+k] - start_cyc[0][base+k-1], 40);
        end

        // Write landing on the edge that ends STOP with an empty FIFO
        wait_idle_a(400);
        base      = start_cyc[0].size();
        rx_before = rx_cnt[0];
        wr_en_a = 1; wr_data_a = 8'h3C;
        exp_q[0].push_back(frame8n1(8'h3C));
        @(negedge clk);
        wr_en_a = 0;
        repeat (40) @(negedge clk);
        wr_en_a = 1; wr_data_a = 8'hC3;
        exp_q[0].push_back(frame8n1(8'hC3));
        @(negedge clk);
        wr_en_a = 0;
        chk("stopedge_count", count_a, 1);
        chk("stopedge_busy", busy_a, 0);
        chk("stopedge_txd", txd_a, 1);
        @(negedge clk);
        chk("stopedge_pop_count", count_a, 0);
        chk("stopedge_pop_txd", txd_a, 0);
        wait_rx(0, rx_before + 2, 200);
        chk("stopedge_gap", start_cyc[0][base+1] - start_cyc[0][base], 41);

        // Reset in the middle of DATA with two bytes queued
        wait_idle_a(200);
        wr_en_a = 1; wr_data_a = 8'h00;
        exp_q[0].push_back(frame8n1(8'h00));
        @(negedge clk);
        wr_data_a = 8'h11;
        @(negedge clk);
        wr_data_a = 8'h22;
        @(negedge clk);
        wr_en_a = 0;
        chk("rstmid_count_pre", count_a, 2);
        repeat (10) @(negedge clk);
        chk("rstmid_txd_pre", txd_a, 0);
        rst_a = 1'b0;
        #1;
        chk("rstmid_txd", txd_a, 1);
        chk("rstmid_count", count_a, 0);
        chk("rstmid_busy", busy_a, 0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        rx_before = rx_cnt[0];
        repeat (60) @(negedge clk);
        chk("rstmid_after_txd", txd_a, 1);
        chk("rstmid_after_busy", busy_a, 0);
        chk("rstmid_no_frame", rx_cnt[0], rx_before);
        chk("rstmid_exp_empty", exp_q[0].size(), 0);

        // Random traffic at two clocks per bit, writes gated by full
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (full_d == 1'b0 && $urandom_range(0, 3) != 0) begin
                wr_en_d = 1;
                wr_data_d = 8'($urandom_range(0, 255));
                exp_q[3].push_back(frame8n1(wr_data_d));
                n++;
            end else begin
                wr_en_d = 0;
            end
        end
        @(negedge clk);
        wr_en_d = 0;
        wait_rx(3, 300, 20000);
        chk("rand_ovf_never", ovf_cnt_d, 0);
        repeat (30) @(negedge clk);
        chk("rand_busy_end", busy_d, 0);

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("exp_left_dut%0d", k), exp_q[k].size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
